// File: rtl/game_core_mp.sv
// game_core_mp: game FSM, up to P_NUM scrolling pipes, bird, score and lives; state steps on iFrameTick.
// Optional macro GAME_SPEEDUP_EN: scroll speed = 1 + score/8, capped at 4 (otherwise constant 1).
module game_core_mp #(
    parameter int H_VIS      = 640,
    parameter int V_VIS      = 480,
    parameter int H_TOT      = 800,
    parameter int V_TOT      = 525,
    parameter int H_SIZE     = $clog2(H_TOT),
    parameter int V_SIZE     = $clog2(V_TOT),
    parameter int P_NUM      = 4,
    parameter int LIVES      = 3,
    parameter int PIPE_W     = 40,
    parameter int GAP_H      = 120,
    parameter int SPACING    = 200,
    parameter int BIRD_X     = 160,
    parameter int BIRD_W     = 16,
    parameter int BIRD_H     = 16,
    parameter int BIRD_STEP  = 2,
    parameter int HIT_FRAMES = 60
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iFrameTick,
    input  logic                      iBtnUP,
    input  logic                      iBtnDOWN,
    input  logic                      iBtnENTER,
    input  logic                      iSwCollision,
    input  logic [V_SIZE-1:0]         iRnd,
    output logic [P_NUM*H_SIZE-1:0]   oPipePos,
    output logic [P_NUM*V_SIZE-1:0]   oWindowsPos,
    output logic [P_NUM-1:0]          oPipeActive,
    output logic [V_SIZE-1:0]         oBirdPos,
    output logic [7:0]                oScore,
    output logic [2:0]                oLives,
    output logic [1:0]                oState
);
    localparam int XW  = H_SIZE + 1;
    localparam int YW  = V_SIZE + 1;
    localparam int HCW = $clog2(HIT_FRAMES + 1);

    localparam logic [XW-1:0]     X_SPAWN    = XW'(H_VIS - 1);
    localparam logic [XW-1:0]     X_PIPE_W   = XW'(PIPE_W);
    localparam logic [XW-1:0]     X_BIRD_X   = XW'(BIRD_X);
    localparam logic [XW-1:0]     X_BIRD_R   = XW'(BIRD_X + BIRD_W);
    localparam logic [XW-1:0]     X_SPACING  = XW'(SPACING);
    localparam logic [V_SIZE-1:0] Y_CENTRE   = V_SIZE'((V_VIS - BIRD_H) / 2);
    localparam logic [V_SIZE-1:0] Y_MAX      = V_SIZE'(V_VIS - BIRD_H);
    localparam logic [V_SIZE-1:0] Y_STEP     = V_SIZE'(BIRD_STEP);
    localparam logic [V_SIZE-1:0] Y_DOWN_LIM = V_SIZE'(V_VIS - BIRD_H - BIRD_STEP);
    localparam logic [V_SIZE-1:0] WIN_MIN    = V_SIZE'(8);
    localparam logic [V_SIZE-1:0] WIN_MAX    = V_SIZE'(V_VIS - GAP_H - 8);
    localparam logic [YW-1:0]     Y_BIRD_H   = YW'(BIRD_H);
    localparam logic [YW-1:0]     Y_GAP_H    = YW'(GAP_H);
    localparam logic [HCW-1:0]    HIT_LAST   = HCW'(HIT_FRAMES - 1);
    localparam logic [2:0]        LIVES_INIT = 3'(LIVES);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;

    state_t              state, stateNext;
    logic                enterQ;
    logic [XW-1:0]       pipeX     [P_NUM];
    logic [XW-1:0]       pipeXNext [P_NUM];
    logic [V_SIZE-1:0]   pipeWin     [P_NUM];
    logic [V_SIZE-1:0]   pipeWinNext [P_NUM];
    logic [P_NUM-1:0]    pipeAct, pipeActNext;
    logic [V_SIZE-1:0]   birdY, birdNext;
    logic [7:0]          score, scoreNext;
    logic [2:0]          lives, livesNext;
    logic [XW-1:0]       spawnCnt, spawnNext, spawnSum;
    logic [HCW-1:0]      hitCnt, hitCntNext;
    logic [XW-1:0]       speed;
    logic [3:0]          passCnt;
    logic                found, hitNow, enterEdge;

    function automatic logic [V_SIZE-1:0] clampWindow(input logic [V_SIZE-1:0] r);
        if (r < WIN_MIN)      return WIN_MIN;
        else if (r > WIN_MAX) return WIN_MAX;
        else                  return r;
    endfunction

    function automatic logic [7:0] satAdd(input logic [7:0] s, input logic [3:0] n);
        logic [8:0] sum;
        sum = {1'b0, s} + 9'(n);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

`ifdef GAME_SPEEDUP_EN
    logic [5:0] speedRaw;
    assign speedRaw = {1'b0, score[7:3]} + 6'd1;
    assign speed    = (speedRaw > 6'd4) ? XW'(4) : XW'(speedRaw);
`else
    assign speed = XW'(1);
`endif

    assign enterEdge = iBtnENTER & ~enterQ;

    // Collision looks only at registered positions, so a hit freezes the frame it was seen in.
    always_comb begin
        hitNow = 1'b0;
        for (int k = 0; k < P_NUM; k++) begin
            if (pipeAct[k] && (pipeX[k] < X_BIRD_R) && ((pipeX[k] + X_PIPE_W) > X_BIRD_X) &&
                ((birdY < pipeWin[k]) ||
                 (({1'b0, birdY} + Y_BIRD_H) > ({1'b0, pipeWin[k]} + Y_GAP_H))))
                hitNow = 1'b1;
        end
    end

    always_comb begin
        stateNext   = state;
        pipeActNext = pipeAct;
        for (int k = 0; k < P_NUM; k++) begin
            pipeXNext[k]   = pipeX[k];
            pipeWinNext[k] = pipeWin[k];
        end
        birdNext   = birdY;
        scoreNext  = score;
        livesNext  = lives;
        spawnNext  = spawnCnt;
        spawnSum   = spawnCnt + speed;
        hitCntNext = hitCnt;
        passCnt    = 4'd0;
        found      = 1'b0;

        case (state)
            IDLE: begin
                if (enterEdge) begin
                    stateNext   = PLAY;
                    pipeActNext = '0;
                    for (int k = 0; k < P_NUM; k++) begin
                        pipeXNext[k]   = '0;
                        pipeWinNext[k] = '0;
                    end
                    scoreNext = 8'd0;
                    spawnNext = '0;
                    livesNext = LIVES_INIT;
                    birdNext  = Y_CENTRE;
                end
            end
            PLAY: begin
                if (iFrameTick) begin
                    if (iSwCollision && hitNow) begin
                        stateNext  = HIT;
                        livesNext  = lives - 3'd1;
                        hitCntNext = '0;
                    end else begin
                        for (int k = 0; k < P_NUM; k++) begin
                            if (pipeAct[k]) begin
                                if (pipeX[k] < speed) begin
                                    pipeActNext[k] = 1'b0;
                                end else begin
                                    pipeXNext[k] = pipeX[k] - speed;
                                    if (((pipeX[k] + X_PIPE_W) > X_BIRD_X) &&
                                        ((pipeXNext[k] + X_PIPE_W) <= X_BIRD_X))
                                        passCnt = passCnt + 4'd1;
                                end
                            end
                        end
                        scoreNext = satAdd(score, passCnt);
                        spawnNext = spawnSum;
                        if (spawnSum >= X_SPACING) begin
                            spawnNext = spawnSum - X_SPACING;
                            // A slot freed by this tick's move is reusable immediately.
                            for (int k = 0; k < P_NUM; k++) begin
                                if (!found && !pipeActNext[k]) begin
                                    found          = 1'b1;
                                    pipeActNext[k] = 1'b1;
                                    pipeXNext[k]   = X_SPAWN;
                                    pipeWinNext[k] = clampWindow(iRnd);
                                end
                            end
                        end
                        case ({iBtnUP, iBtnDOWN})
                            2'b10:   birdNext = (birdY < Y_STEP) ? '0 : birdY - Y_STEP;
                            2'b01:   birdNext = (birdY > Y_DOWN_LIM) ? Y_MAX : birdY + Y_STEP;
                            default: birdNext = birdY;
                        endcase
                    end
                end
            end
            HIT: begin
                if (iFrameTick) begin
                    if (hitCnt == HIT_LAST) begin
                        if (lives != 3'd0) begin
                            stateNext   = PLAY;
                            pipeActNext = '0;
                            for (int k = 0; k < P_NUM; k++) begin
                                pipeXNext[k]   = '0;
                                pipeWinNext[k] = '0;
                            end
                            spawnNext = '0;
                            birdNext  = Y_CENTRE;
                        end else begin
                            stateNext = OVER;
                        end
                    end else begin
                        hitCntNext = hitCnt + HCW'(1);
                    end
                end
            end
            OVER: begin
                if (enterEdge) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            enterQ   <= 1'b0;
            pipeAct  <= '0;
            for (int k = 0; k < P_NUM; k++) begin
                pipeX[k]   <= '0;
                pipeWin[k] <= '0;
            end
            birdY    <= Y_CENTRE;
            score    <= 8'd0;
            lives    <= LIVES_INIT;
            spawnCnt <= '0;
            hitCnt   <= '0;
        end else begin
            state    <= stateNext;
            enterQ   <= iBtnENTER;
            pipeAct  <= pipeActNext;
            for (int k = 0; k < P_NUM; k++) begin
                pipeX[k]   <= pipeXNext[k];
                pipeWin[k] <= pipeWinNext[k];
            end
            birdY    <= birdNext;
            score    <= scoreNext;
            lives    <= livesNext;
            spawnCnt <= spawnNext;
            hitCnt   <= hitCntNext;
        end
    end

    for (genvar k = 0; k < P_NUM; k++) begin : gPipeOut
        assign oPipePos[k*H_SIZE +: H_SIZE]    = pipeX[k][H_SIZE-1:0];
        assign oWindowsPos[k*V_SIZE +: V_SIZE] = pipeWin[k];
    end

    assign oPipeActive = pipeAct;
    assign oBirdPos    = birdY;
    assign oScore      = score;
    assign oLives      = lives;
    assign oState      = state;
endmodule
